// File: rtl/traffic_light_monitor.sv
// Safety monitor between the traffic-light FSM and the LED drivers: filters lamp glitches,
// checks one-hot encoding, cross-road conflicts and colour order, and latches a flashing-red fault.
module traffic_light_monitor #(
    parameter int FILTER_CYC = 2,
    parameter int INIT_CYC   = 3,
    parameter int FLASH_HALF = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    input  logic             fault_clr,
    output logic [2:0]       led_M1,
    output logic [2:0]       led_M2,
    output logic [2:0]       led_MT,
    output logic [2:0]       led_S,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int NR = 4;
    localparam int FW = $clog2(FILTER_CYC + 1);
    localparam int IW = $clog2(INIT_CYC + 1);
    localparam int HW = $clog2(FLASH_HALF + 1);

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PASS,
        ST_FAULT
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_init_cnt;
    logic [HW-1:0]    r_flash_cnt;
    logic             r_phase;
    logic [2:0]       r_led [NR];
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [CNT_W-1:0] r_fault_cnt;
    logic [FW-1:0]    r_vio_cnt;

    logic [2:0]       w_pin [NR];
    logic [2:0]       w_in  [NR];
    logic [NR-1:0]    w_onehot;
    logic [NR-1:0]    w_not_red;
    logic [NR-1:0]    w_seq_vio;
    logic             w_enc;
    logic             w_conf;
    logic             w_vio;
    logic             w_confirm;
    logic             w_seq_any;
    logic [2:0]       w_cause;
    logic             w_enter;

    // Road index order: 0=M1, 1=M2, 2=MT, 3=S
    assign w_pin[0] = light_M1;
    assign w_pin[1] = light_M2;
    assign w_pin[2] = light_MT;
    assign w_pin[3] = light_S;

    function automatic logic [2:0] f_next(input logic [2:0] v);
        case (v)
            LAMP_G:  return LAMP_Y;
            LAMP_Y:  return LAMP_R;
            LAMP_R:  return LAMP_G;
            default: return 3'b000;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_road
            logic [2:0]    r_in;
            logic [2:0]    r_last_good;
            logic [FW-1:0] r_stab;
            logic          w_settled;
            logic          w_order_ok;

            // Stability counter saturates above the settle point so each value settles once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_in   <= LAMP_R;
                    r_stab <= '0;
                end else begin
                    r_in <= w_pin[gi];
                    if (w_pin[gi] != r_in) begin
                        r_stab <= '0;
                    end else if (r_stab != FW'(FILTER_CYC)) begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
            end

            assign w_in[gi]      = r_in;
            assign w_onehot[gi]  = (r_in == LAMP_G) || (r_in == LAMP_Y) || (r_in == LAMP_R);
            assign w_not_red[gi] = (r_in != LAMP_R);
            assign w_settled     = (r_stab == FW'(FILTER_CYC - 1));
            assign w_order_ok    = (r_in == r_last_good) || (r_in == f_next(r_last_good));
            assign w_seq_vio[gi] = w_settled && w_onehot[gi] && !w_order_ok && (r_state == ST_PASS);

            // Outside PASS the road simply resynchronises to whatever it settles on.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_last_good <= LAMP_R;
                end else if (w_settled && w_onehot[gi] && (r_state != ST_PASS || w_order_ok)) begin
                    r_last_good <= r_in;
                end
            end
        end
    endgenerate

    assign w_enc  = ~&w_onehot;
    assign w_conf = (w_not_red[3] && (w_not_red[0] || w_not_red[1] || w_not_red[2]))
                  || (w_not_red[2] && w_not_red[1]);
    assign w_vio  = w_enc || w_conf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vio_cnt <= '0;
        end else if (!w_vio) begin
            r_vio_cnt <= '0;
        end else if (r_vio_cnt != FW'(FILTER_CYC)) begin
            r_vio_cnt <= r_vio_cnt + 1'b1;
        end
    end

    assign w_confirm = w_vio && (r_vio_cnt == FW'(FILTER_CYC - 1));
    assign w_seq_any = |w_seq_vio;
    assign w_cause   = {w_seq_any, w_confirm && w_enc, w_confirm && w_conf};
    assign w_enter   = ((r_state == ST_INIT) && w_confirm)
                     || ((r_state == ST_PASS) && (w_confirm || w_seq_any));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_flash_cnt  <= '0;
            r_phase      <= 1'b1;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_fault_cnt  <= '0;
            for (int k = 0; k < NR; k++) begin
                r_led[k] <= LAMP_R;
            end
        end else begin
            case (r_state)
                ST_INIT: begin
                    for (int k = 0; k < NR; k++) begin
                        r_led[k] <= LAMP_R;
                    end
                    if (r_init_cnt == IW'(INIT_CYC - 1)) begin
                        r_state    <= ST_PASS;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_PASS: begin
                    for (int k = 0; k < NR; k++) begin
                        r_led[k] <= w_in[k];
                    end
                end
                ST_FAULT: begin
                    for (int k = 0; k < NR; k++) begin
                        r_led[k] <= {r_phase, 2'b00};
                    end
                    if (r_flash_cnt == HW'(FLASH_HALF - 1)) begin
                        r_flash_cnt <= '0;
                        r_phase     <= ~r_phase;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                    end
                    // A clear is honoured only on a clean clock; otherwise the fault stays latched.
                    if (fault_clr && !w_vio) begin
                        r_state    <= ST_INIT;
                        r_init_cnt <= '0;
                        r_fault    <= 1'b0;
                        for (int k = 0; k < NR; k++) begin
                            r_led[k] <= LAMP_R;
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase

            // Fault entry overrides the per-state next state; LEDs flash from the following edge.
            if (w_enter) begin
                r_state      <= ST_FAULT;
                r_fault      <= 1'b1;
                r_fault_code <= r_fault_code | w_cause;
                r_phase      <= 1'b1;
                r_flash_cnt  <= '0;
                if (r_fault_cnt != {CNT_W{1'b1}}) begin
                    r_fault_cnt <= r_fault_cnt + 1'b1;
                end
            end
        end
    end

    assign led_M1     = r_led[0];
    assign led_M2     = r_led[1];
    assign led_MT     = r_led[2];
    assign led_S      = r_led[3];
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign fault_cnt  = r_fault_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed table-driven bench for traffic_light_monitor, plus hand sequences for
// asynchronous reset, reset during INIT and fault counter saturation.
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    // Packed lamp vectors {M1, M2, MT, S}
    localparam logic [11:0] S1    = {G, G, R, R};
    localparam logic [11:0] S2    = {G, Y, R, R};
    localparam logic [11:0] S3    = {G, R, G, R};
    localparam logic [11:0] S4    = {Y, R, Y, R};
    localparam logic [11:0] S5    = {R, R, R, G};
    localparam logic [11:0] S6    = {R, R, R, Y};
    localparam logic [11:0] RED4  = {R, R, R, R};
    localparam logic [11:0] OFF4  = 12'h000;
    localparam logic [11:0] CONF  = {G, G, R, G};
    localparam logic [11:0] SKIP  = {G, R, R, R};
    localparam logic [11:0] BADM1 = {3'b011, G, R, R};
    localparam logic [11:0] MULTI = {G, G, R, 3'b011};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] light_M1 = R;
    logic [2:0] light_M2 = R;
    logic [2:0] light_MT = R;
    logic [2:0] light_S  = R;
    logic       fault_clr = 1'b0;
    logic [2:0] led_M1, led_M2, led_MT, led_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rb;
        logic [11:0] in;
        logic        clr;
        logic [11:0] led;
        logic        f;
        logic [2:0]  code;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .fault_clr  (fault_clr),
        .led_M1     (led_M1),
        .led_M2     (led_M2),
        .led_MT     (led_MT),
        .led_S      (led_S),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void add(input logic rb, input logic [11:0] in, input logic clr,
                                input logic [11:0] led, input logic f,
                                input logic [2:0] code, input logic [7:0] cnt);
        vec_t v;
        v.rb = rb; v.in = in; v.clr = clr; v.led = led;
        v.f = f; v.code = code; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] in);
        {light_M1, light_M2, light_MT, light_S} = in;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_led"},   {led_M1, led_M2, led_MT, led_S}, RED4);
        chk({tag, "_fault"}, fault, 1'b0);
        chk({tag, "_code"},  fault_code, 3'b000);
        chk({tag, "_cnt"},   fault_cnt, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fault_clr = 1'b0;
        drive(RED4);
        tick();
        check_reset_vals("reset");
        $display("reset applied led=%h fault=%b code=%b cnt=%0d",
                 {led_M1, led_M2, led_MT, led_S}, fault, fault_code, fault_cnt);
        rst = 1'b0;
    endtask

    initial begin
        // Segment A: INIT, normal cycle, ignored clear, glitch, conflict fault, clear attempts
        add(1, S1, 0, RED4, 0, 3'b000, 0);
        add(0, S1, 0, RED4, 0, 3'b000, 0);
        add(0, S1, 0, RED4, 0, 3'b000, 0);
        add(0, S1, 0, S1,   0, 3'b000, 0);
        add(0, S2, 0, S1,   0, 3'b000, 0);
        add(0, S2, 0, S2,   0, 3'b000, 0);
        add(0, S3, 1, S2,   0, 3'b000, 0);
        add(0, S3, 0, S3,   0, 3'b000, 0);
        add(0, S4, 0, S3,   0, 3'b000, 0);
        add(0, S4, 0, S4,   0, 3'b000, 0);
        add(0, S5, 0, S4,   0, 3'b000, 0);
        add(0, S5, 0, S5,   0, 3'b000, 0);
        add(0, S6, 0, S5,   0, 3'b000, 0);
        add(0, S6, 0, S6,   0, 3'b000, 0);
        add(0, S1, 0, S6,   0, 3'b000, 0);
        add(0, S1, 0, S1,   0, 3'b000, 0);
        add(0, CONF, 0, S1,   0, 3'b000, 0);
        add(0, S1,   0, CONF, 0, 3'b000, 0);
        add(0, S1,   0, S1,   0, 3'b000, 0);
        add(0, S1,   0, S1,   0, 3'b000, 0);
        add(0, CONF, 0, S1,   0, 3'b000, 0);
        add(0, CONF, 0, CONF, 0, 3'b000, 0);
        add(0, CONF, 0, CONF, 1, 3'b001, 1);
        add(0, CONF, 0, RED4, 1, 3'b001, 1);
        add(0, CONF, 1, OFF4, 1, 3'b001, 1);
        add(0, S1,   0, RED4, 1, 3'b001, 1);
        add(0, S1,   1, RED4, 0, 3'b001, 1);
        add(0, S1,   0, RED4, 0, 3'b001, 1);
        add(0, S1,   0, RED4, 0, 3'b001, 1);
        add(0, S1,   0, RED4, 0, 3'b001, 1);
        add(0, S1,   0, S1,   0, 3'b001, 1);
        add(0, S1,   0, S1,   0, 3'b001, 1);
        // Segment B: M2 skips yellow -> sequence fault
        add(1, S1,   0, RED4, 0, 3'b000, 0);
        add(0, S1,   0, RED4, 0, 3'b000, 0);
        add(0, S1,   0, RED4, 0, 3'b000, 0);
        add(0, S1,   0, S1,   0, 3'b000, 0);
        add(0, SKIP, 0, S1,   0, 3'b000, 0);
        add(0, SKIP, 0, SKIP, 0, 3'b000, 0);
        add(0, SKIP, 0, SKIP, 1, 3'b100, 1);
        add(0, SKIP, 0, RED4, 1, 3'b100, 1);
        add(0, SKIP, 0, OFF4, 1, 3'b100, 1);
        // Segment C: M1 not one-hot -> encoding fault
        add(1, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, S1,    0, 3'b000, 0);
        add(0, BADM1, 0, S1,    0, 3'b000, 0);
        add(0, BADM1, 0, BADM1, 0, 3'b000, 0);
        add(0, BADM1, 0, BADM1, 1, 3'b010, 1);
        add(0, BADM1, 0, RED4,  1, 3'b010, 1);
        add(0, BADM1, 0, OFF4,  1, 3'b010, 1);
        // Segment D: conflict and encoding in the same clock
        add(1, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, RED4,  0, 3'b000, 0);
        add(0, S1,    0, S1,    0, 3'b000, 0);
        add(0, MULTI, 0, S1,    0, 3'b000, 0);
        add(0, MULTI, 0, MULTI, 0, 3'b000, 0);
        add(0, MULTI, 0, MULTI, 1, 3'b011, 1);
        add(0, MULTI, 0, RED4,  1, 3'b011, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rb) do_reset();
            drive(vecs[i].in);
            fault_clr = vecs[i].clr;
            tick();
            chk($sformatf("row%0d_led", i), {led_M1, led_M2, led_MT, led_S}, vecs[i].led);
            chk($sformatf("row%0d_fault", i), fault, vecs[i].f);
            chk($sformatf("row%0d_code", i), fault_code, vecs[i].code);
            chk($sformatf("row%0d_cnt", i), fault_cnt, vecs[i].cnt);
            $display("row %0d in=%h clr=%b led=%h fault=%b code=%b cnt=%0d", i, vecs[i].in,
                     vecs[i].clr, {led_M1, led_M2, led_MT, led_S}, fault, fault_code, fault_cnt);
        end
        fault_clr = 1'b0;

        // Asynchronous reset while in FAULT: outputs return before the next clock edge
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst_fault");
        $display("async reset in FAULT led=%h fault=%b code=%b cnt=%0d",
                 {led_M1, led_M2, led_MT, led_S}, fault, fault_code, fault_cnt);
        tick();
        rst = 1'b0;

        // Repeated fault entries from INIT until the counter saturates
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(CONF);
            tick();
            tick();
            tick();
            chk($sformatf("sat%0d_fault", i), fault, 1'b1);
            chk($sformatf("sat%0d_cnt", i), fault_cnt, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            $display("entry %0d fault=%b code=%b cnt=%0d", i, fault, fault_code, fault_cnt);
            drive(S1);
            tick();
            fault_clr = 1'b1;
            tick();
            fault_clr = 1'b0;
            chk($sformatf("sat%0d_clear", i), fault, 1'b0);
        end
        tick();
        chk("sat_final_cnt", fault_cnt, 8'd255);
        chk("sat_final_code", fault_code, 3'b001);

        // Asynchronous reset while in INIT
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst_init");
        $display("async reset in INIT led=%h fault=%b code=%b cnt=%0d",
                 {led_M1, led_M2, led_MT, led_S}, fault, fault_code, fault_cnt);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Safety stage directly downstream of the traffic-light FSM.
- Consumes the four 3-bit lamp buses (M1, M2, MT, S), filters glitches, and checks encoding, cross-road conflicts and the per-road colour sequence.
- Passes clean lamp states to the physical LED drivers.
- On any persistent violation it latches a fault and forces flashing all-red until an operator clear on clean inputs.

Parameters:
- FILTER_CYC, 2: consecutive clocks a violation or new value must persist before it is acted on (>=1).
- INIT_CYC, 3: all-red clearance clocks after reset or fault clear.
- FLASH_HALF, 1: clocks per half-period of fault flashing.
- CNT_W, 8: width of the saturating fault counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- light_M1  in  3  main road 1 lamps; 001=green, 010=yellow, 100=red
- light_M2  in  3  main road 2 lamps, same encoding
- light_MT  in  3  main-through lamps, same encoding
- light_S  in  3  side road lamps, same encoding
- fault_clr  in  1  single-cycle operator clear request
- led_M1, led_M2, led_MT, led_S  out  3 each  registered lamp drive, same encoding
- fault  out  1  high while in FAULT
- fault_code  out  3  sticky cause: bit0 conflict, bit1 encoding, bit2 sequence
- fault_cnt  out  CNT_W  number of FAULT entries, saturating

Behaviour:
- Reset:
  - All led_* = 100 (red).
  - fault = 0, fault_code = 0, fault_cnt = 0.
  - State INIT, all counters 0, last_good[*] = 100.
- Input stage: all four buses registered (in_r) every clk. Checks operate on in_r.
- Encoding violation: any in_r not exactly one-hot.
- Conflict violation:
  - S not red while any of M1, M2, MT is not red; or
  - MT not red while M2 not red.
  - M1 may coexist with M2 or MT.
- Filter:
  - vio_cnt increments on each clk with an encoding or conflict violation present, and clears on any clean clk.
  - When a violation is present and vio_cnt == FILTER_CYC-1, the violation is "confirmed".
- Sequence check, per road:
  - stab_cnt clears when in_r changes and otherwise increments, saturating.
  - A road is "settled" on a clk where stab_cnt == FILTER_CYC-1.
  - On settling, a valid value that equals last_good or is its legal successor (001->010, 010->100, 100->001) loads last_good.
  - Any other settled valid value is a confirmed sequence violation.
  - In INIT and FAULT, settled valid values load last_good without checking.
- FSM:
  - INIT:
    - Drive all red; count INIT_CYC clks, then go to PASS.
    - A confirmed conflict or encoding violation goes to FAULT instead.
  - PASS:
    - led_* <= in_r each clk, giving 2-clk latency from the input pins.
    - Any confirmed violation goes to FAULT.
  - FAULT:
    - fault = 1.
    - led_* = {phase,0,0} on every road; phase starts at 1 and toggles every FLASH_HALF clks, so red flashes while green and yellow stay off.
    - Go to INIT when fault_clr = 1 and there is no violation on in_r in that clk; otherwise stay.
- Fault entry:
  - fault is registered, high on the edge of confirmation; the LED flash pattern appears on the next edge.
  - fault_code |= the causes confirmed in the entry clk.
  - fault_cnt increments, saturating at all-ones.
- fault_code persists across clear and is only zeroed by rst.
- Boundary cases:
  - fault_clr outside FAULT is ignored.
  - fault_clr in the same clk as a violation keeps FAULT and does not increment fault_cnt.
  - Multiple causes in one clk set multiple bits.
  - rst mid-FAULT or mid-INIT returns immediately to the reset values.

Test Plan:
- Normal cycle, inputs stepping S1..S6 (M1=001, M2=001, MT=100, S=100, etc.) -> led_* follow with 2-clk latency; fault stays 0 after INIT (3 clks all-red).
- S=001 with M1=001 held 2 clks in PASS -> fault=1 at the 2nd edge after capture; fault_code=001; fault_cnt=1; led_* = 100/000 alternating every clk thereafter.
- Same conflict held 1 clk only, then clean -> no fault; led_* show the glitch value for one clk.
- M2: 001 held, then 100 held for 2 clks (yellow skipped) -> fault_code=100. Separately, M1=011 for 2 clks -> fault_code=010.
- Fault clears:
  - fault_clr pulsed while the conflict persists -> remains FAULT, fault_cnt unchanged.
  - Inputs cleaned, then fault_clr -> INIT: 3 clks all-red, then PASS; fault_code is retained.
- rst asserted mid-FAULT -> outputs immediately red, fault=0, fault_code=0, fault_cnt=0.
- 256 forced fault entries -> fault_cnt saturates at 255.
